// File: rtl/mux3_select_arbiter.sv
// Round-robin arbiter for three requesters driving a dual-rail 3:1 mux select.
// Define MUX3_SEL_TIMEOUT_EN to add a hold counter that force-releases a grant after MAX_HOLD cycles.
module mux3_select_arbiter #(
    parameter int MAX_HOLD = 15
) (
    input  logic       Clock,
    input  logic       _Reset,
    input  logic [2:0] Req,
    input  logic       Done,
    output logic [2:0] Grant,
    output logic [1:0] Select,
    output logic [1:0] _Select,
    output logic       Busy,
    output logic       Timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] grant_next;
    logic [1:0] select_next;
    logic [1:0] last_winner;
    logic [1:0] last_winner_next;
    logic [1:0] winner;
    logic       expire;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 1..15");
    end

`ifdef MUX3_SEL_TIMEOUT_EN
    logic [3:0] hold_count;

    // Counter value is the number of GRANT cycles already completed, so the
    // MAX_HOLD-th GRANT cycle is the one where it reads MAX_HOLD-1.
    always_ff @(posedge Clock or negedge _Reset) begin
        if (!_Reset)
            hold_count <= 4'd0;
        else if (state == GRANT)
            hold_count <= hold_count + 4'd1;
        else
            hold_count <= 4'd0;
    end

    assign expire  = (state == GRANT) && (hold_count == 4'(MAX_HOLD - 1));
    assign Timeout = expire && !Done;
`else
    assign expire  = 1'b0;
    assign Timeout = 1'b0;
`endif

    // Search starts one past the previous winner; the index never reaches 3.
    always_comb begin
        winner = 2'd0;
        case (last_winner)
            2'd0:    winner = Req[1] ? 2'd1 : (Req[2] ? 2'd2 : 2'd0);
            2'd1:    winner = Req[2] ? 2'd2 : (Req[0] ? 2'd0 : 2'd1);
            default: winner = Req[0] ? 2'd0 : (Req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_next       = state;
        grant_next       = Grant;
        select_next      = Select;
        last_winner_next = last_winner;
        case (state)
            IDLE: begin
                if (|Req) begin
                    state_next       = GRANT;
                    grant_next       = 3'b001 << winner;
                    select_next      = winner;
                    last_winner_next = winner;
                end
            end
            GRANT: begin
                if (Done || expire) begin
                    state_next = RELEASE;
                    grant_next = 3'b000;
                end
            end
            RELEASE: state_next = IDLE;
            default: begin
                state_next = IDLE;
                grant_next = 3'b000;
            end
        endcase
    end

    // Select is left untouched outside the grant load so the mux stays parked.
    always_ff @(posedge Clock or negedge _Reset) begin
        if (!_Reset) begin
            state       <= IDLE;
            Grant       <= 3'b000;
            Select      <= 2'b00;
            _Select     <= 2'b11;
            last_winner <= 2'd2;
        end else begin
            state       <= state_next;
            Grant       <= grant_next;
            Select      <= select_next;
            _Select     <= ~select_next;
            last_winner <= last_winner_next;
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_mux3_select_arbiter.sv
// Directed self-checking bench for mux3_select_arbiter; the timeout section
// follows MUX3_SEL_TIMEOUT_EN the same way the design does.
module tb_mux3_select_arbiter;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [1:0] select;
    logic [1:0] select_n;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    mux3_select_arbiter #(.MAX_HOLD(4)) dut (
        .Clock   (clock),
        ._Reset  (rst_n),
        .Req     (req),
        .Done    (done),
        .Grant   (grant),
        .Select  (select),
        ._Select (select_n),
        .Busy    (busy),
        .Timeout (timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // The complement rail is checked against the inverse of the expected select.
    task automatic checkState(input string tag, input logic [2:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        checkOutput({tag, ".grant"},   {5'd0, grant},    {5'd0, g});
        checkOutput({tag, ".select"},  {6'd0, select},   {6'd0, s});
        checkOutput({tag, ".nselect"}, {6'd0, select_n}, {6'd0, ~s});
        checkOutput({tag, ".busy"},    {7'd0, busy},     {7'd0, b});
        checkOutput({tag, ".timeout"}, {7'd0, timeout},  {7'd0, t});
    endtask

    initial begin
        logic [2:0] exp_grant [3];
        logic [1:0] exp_sel   [3];
        logic [2:0] prev_grant;
        logic [1:0] prev_sel;
        int         held;

        exp_grant = '{3'b010, 3'b100, 3'b001};
        exp_sel   = '{2'b01, 2'b10, 2'b00};

        rst_n = 1'b0;
        applyStimulus(3'b111, 1'b0);
        tick();
        tick();
        checkState("reset", 3'b000, 2'b00, 1'b0, 1'b0);

        rst_n = 1'b1;
        tick();
        checkState("first_grant", 3'b001, 2'b00, 1'b1, 1'b0);

        prev_grant = 3'b001;
        prev_sel   = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkState($sformatf("rr%0d.hold", k), prev_grant, prev_sel, 1'b1, 1'b0);
            applyStimulus(3'b111, 1'b1);
            tick();
            applyStimulus(3'b111, 1'b0);
            checkState($sformatf("rr%0d.release", k), 3'b000, prev_sel, 1'b1, 1'b0);
            tick();
            checkState($sformatf("rr%0d.idle", k), 3'b000, prev_sel, 1'b0, 1'b0);
            tick();
            checkState($sformatf("rr%0d.grant", k), exp_grant[k], exp_sel[k], 1'b1, 1'b0);
            prev_grant = exp_grant[k];
            prev_sel   = exp_sel[k];
        end

        applyStimulus(3'b010, 1'b1);
        tick();
        applyStimulus(3'b010, 1'b0);
        checkState("src1.release0", 3'b000, 2'b00, 1'b1, 1'b0);
        tick();
        checkState("src1.idle0", 3'b000, 2'b00, 1'b0, 1'b0);
        tick();
        checkState("src1.grant", 3'b010, 2'b01, 1'b1, 1'b0);

        applyStimulus(3'b101, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkState($sformatf("src1.hold%0d", k), 3'b010, 2'b01, 1'b1, 1'b0);
        end
        applyStimulus(3'b101, 1'b1);
        tick();
        applyStimulus(3'b101, 1'b0);
        checkState("src1.release", 3'b000, 2'b01, 1'b1, 1'b0);
        tick();
        checkState("src1.idle", 3'b000, 2'b01, 1'b0, 1'b0);
        tick();
        checkState("src2.grant", 3'b100, 2'b10, 1'b1, 1'b0);

        #2 rst_n = 1'b0;
        #1 checkState("async_reset", 3'b000, 2'b00, 1'b0, 1'b0);
        @(negedge clock);
        checkState("reset_held", 3'b000, 2'b00, 1'b0, 1'b0);

        rst_n = 1'b1;
        applyStimulus(3'b000, 1'b1);
        tick();
        checkState("done_in_idle", 3'b000, 2'b00, 1'b0, 1'b0);
        applyStimulus(3'b110, 1'b0);
        tick();
        checkState("post_reset_rr", 3'b010, 2'b01, 1'b1, 1'b0);

        applyStimulus(3'b001, 1'b1);
        tick();
        applyStimulus(3'b001, 1'b0);
        checkState("hold.release", 3'b000, 2'b01, 1'b1, 1'b0);
        tick();
        tick();
        checkState("hold.grant", 3'b001, 2'b00, 1'b1, 1'b0);

`ifdef MUX3_SEL_TIMEOUT_EN
        tick();
        checkState("to.cycle2", 3'b001, 2'b00, 1'b1, 1'b0);
        tick();
        checkState("to.cycle3", 3'b001, 2'b00, 1'b1, 1'b0);
        tick();
        checkState("to.cycle4", 3'b001, 2'b00, 1'b1, 1'b1);
        tick();
        checkState("to.release", 3'b000, 2'b00, 1'b1, 1'b0);
        tick();
        tick();
        checkState("to.regrant", 3'b001, 2'b00, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(3'b001, 1'b1);
        checkState("to.done_wins", 3'b001, 2'b00, 1'b1, 1'b0);
        tick();
        applyStimulus(3'b001, 1'b0);
        checkState("to.done_release", 3'b000, 2'b00, 1'b1, 1'b0);
`else
        held = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (grant === 3'b001 && timeout === 1'b0 && busy === 1'b1)
                held++;
        end
        checkOutput("hold_100_cycles", 8'(held), 8'd100);
        checkState("hold.end", 3'b001, 2'b00, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
